// File: rtl/ct_hpcp_cntx_acc.sv
// One performance-monitor counter: a registered, event-gated increment feeding a
// 64-bit wrap-around accumulator with a sticky overflow flag and an interrupt pulse.
module ct_hpcp_cntx_acc #(
  parameter int unsigned EVT_MAX = 42
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic [3:0]  mhpmcntx_adder,
  input  logic [5:0]  mhpmevtx_value,
  input  logic        hpcp_cnt_en,
  input  logic        mhpmcntx_wen,
  input  logic [63:0] mhpmcntx_wdata,
  input  logic        mhpmcntx_ovf_clr,
  output logic [63:0] mhpmcntx_value,
  output logic        mhpmcntx_ovf,
  output logic        mhpmcntx_ovf_int
);

  localparam logic [5:0] EVT_MAX_CODE = 6'(EVT_MAX);

  logic        sel_valid;
  logic [3:0]  inc_nxt;
  logic [3:0]  inc_ff;
  logic [63:0] cnt_ff;
  logic [64:0] cnt_sum;
  logic        cnt_carry;
  logic        ovf_ff;
  logic        ovf_int_ff;

  // The mux forces a clean zero so an X on the adder never enters the pipeline.
  always_comb begin
    sel_valid = hpcp_cnt_en && (mhpmevtx_value != 6'd0) && (mhpmevtx_value <= EVT_MAX_CODE);
    inc_nxt   = 4'd0;
    if (sel_valid && !mhpmcntx_wen)
      inc_nxt = mhpmcntx_adder;
  end

  always_comb begin
    cnt_sum   = {1'b0, cnt_ff} + {61'd0, inc_ff};
    cnt_carry = cnt_sum[64] && !mhpmcntx_wen;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst)
      inc_ff <= 4'd0;
    else
      inc_ff <= inc_nxt;
  end

  // A CSR write replaces the sum outright, so the in-flight increment is dropped.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst)
      cnt_ff <= 64'd0;
    else if (mhpmcntx_wen)
      cnt_ff <= mhpmcntx_wdata;
    else
      cnt_ff <= cnt_sum[63:0];
  end

  // Setting the flag outranks clearing it so a coincident overflow is never lost.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      ovf_ff     <= 1'b0;
      ovf_int_ff <= 1'b0;
    end else begin
      ovf_int_ff <= cnt_carry;
      if (cnt_carry)
        ovf_ff <= 1'b1;
      else if (mhpmcntx_ovf_clr)
        ovf_ff <= 1'b0;
    end
  end

  assign mhpmcntx_value   = cnt_ff;
  assign mhpmcntx_ovf     = ovf_ff;
  assign mhpmcntx_ovf_int = ovf_int_ff;

endmodule

// File: tb/tb_ct_hpcp_cntx_acc.sv
// Directed bench for ct_hpcp_cntx_acc: inputs change 1 time unit after each rising
// edge, and outputs are checked in that same window before the next edge.
module tb_ct_hpcp_cntx_acc;

  logic        forever_cpuclk;
  logic        cpurst;
  logic [3:0]  mhpmcntx_adder;
  logic [5:0]  mhpmevtx_value;
  logic        hpcp_cnt_en;
  logic        mhpmcntx_wen;
  logic [63:0] mhpmcntx_wdata;
  logic        mhpmcntx_ovf_clr;
  logic [63:0] mhpmcntx_value;
  logic        mhpmcntx_ovf;
  logic        mhpmcntx_ovf_int;

  int checks = 0;
  int errors = 0;

  ct_hpcp_cntx_acc #(.EVT_MAX(42)) dut (
    .forever_cpuclk   (forever_cpuclk),
    .cpurst           (cpurst),
    .mhpmcntx_adder   (mhpmcntx_adder),
    .mhpmevtx_value   (mhpmevtx_value),
    .hpcp_cnt_en      (hpcp_cnt_en),
    .mhpmcntx_wen     (mhpmcntx_wen),
    .mhpmcntx_wdata   (mhpmcntx_wdata),
    .mhpmcntx_ovf_clr (mhpmcntx_ovf_clr),
    .mhpmcntx_value   (mhpmcntx_value),
    .mhpmcntx_ovf     (mhpmcntx_ovf),
    .mhpmcntx_ovf_int (mhpmcntx_ovf_int)
  );

  initial begin
    forever_cpuclk = 1'b0;
    forever #5 forever_cpuclk = ~forever_cpuclk;
  end

  task automatic step();
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [5:0] sel, input logic [3:0] adder,
                               input logic wen, input logic [63:0] wdata, input logic clr);
    hpcp_cnt_en      = en;
    mhpmevtx_value   = sel;
    mhpmcntx_adder   = adder;
    mhpmcntx_wen     = wen;
    mhpmcntx_wdata   = wdata;
    mhpmcntx_ovf_clr = clr;
  endtask

  // Uses !== so that an X or Z on the DUT output counts as a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  logic [63:0] cnt_exp [6];
  logic [5:0]  bad_sel [7];
  logic [3:0]  bad_add [7];

  initial begin
    cnt_exp = '{64'd0, 64'd0, 64'd3, 64'd6, 64'd9, 64'd12};
    bad_sel = '{6'd0, 6'd0, 6'd43, 6'd43, 6'd43, 6'd0, 6'd63};
    bad_add = '{4'bxxxx, 4'bxxxx, 4'bxxxx, 4'hF, 4'hF, 4'hF, 4'hF};

    cpurst = 1'b1;
    applyStimulus(1'b0, 6'd0, 4'd0, 1'b0, 64'd0, 1'b0);
    step();
    step();
    checkOutput("reset_value", mhpmcntx_value, 64'd0);
    checkOutput("reset_ovf", {63'd0, mhpmcntx_ovf}, 64'd0);
    checkOutput("reset_ovf_int", {63'd0, mhpmcntx_ovf_int}, 64'd0);

    // Basic counting: adder=3 for cycles 0..3, visible two cycles later.
    cpurst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, 6'd1, (c < 4) ? 4'd3 : 4'd0, 1'b0, 64'd0, 1'b0);
      checkOutput($sformatf("count_c%0d", c), mhpmcntx_value, cnt_exp[c]);
      step();
    end

    // Invalid selects (including X adder) and disabled counting must not move the value.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, bad_sel[i], bad_add[i], 1'b0, 64'd0, 1'b0);
      checkOutput($sformatf("bad_sel_%0d", i), mhpmcntx_value, 64'd12);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 6'd1, 4'hF, 1'b0, 64'd0, 1'b0);
      checkOutput($sformatf("disabled_%0d", i), mhpmcntx_value, 64'd12);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 6'd0, 4'd0, 1'b0, 64'd0, 1'b0);
      checkOutput($sformatf("bad_settle_%0d", i), mhpmcntx_value, 64'd12);
      step();
    end

    // Highest valid select code counts.
    applyStimulus(1'b1, 6'd42, 4'd1, 1'b0, 64'd0, 1'b0);
    step();
    applyStimulus(1'b0, 6'd0, 4'd0, 1'b0, 64'd0, 1'b0);
    checkOutput("evt_max_c1", mhpmcntx_value, 64'd12);
    step();
    checkOutput("evt_max_c2", mhpmcntx_value, 64'd13);

    // Overflow from FFFF_FFFF_FFFF_FFFE + 5.
    applyStimulus(1'b0, 6'd0, 4'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    step();
    applyStimulus(1'b1, 6'd1, 4'd5, 1'b0, 64'd0, 1'b0);
    checkOutput("ovf_wr_value", mhpmcntx_value, 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("ovf_wr_noovf", {63'd0, mhpmcntx_ovf}, 64'd0);
    step();
    applyStimulus(1'b1, 6'd1, 4'd0, 1'b0, 64'd0, 1'b0);
    checkOutput("ovf_pre_int", {63'd0, mhpmcntx_ovf_int}, 64'd0);
    step();
    checkOutput("ovf_value", mhpmcntx_value, 64'd3);
    checkOutput("ovf_flag", {63'd0, mhpmcntx_ovf}, 64'd1);
    checkOutput("ovf_int_on", {63'd0, mhpmcntx_ovf_int}, 64'd1);
    step();
    checkOutput("ovf_int_off", {63'd0, mhpmcntx_ovf_int}, 64'd0);
    for (int i = 0; i < 10; i++) step();
    checkOutput("ovf_sticky", {63'd0, mhpmcntx_ovf}, 64'd1);
    checkOutput("ovf_idle_value", mhpmcntx_value, 64'd3);

    // Write collision: the adder=2 in flight and the adder=7 with the write are both dropped.
    applyStimulus(1'b1, 6'd1, 4'd2, 1'b0, 64'd0, 1'b0);
    step();
    applyStimulus(1'b1, 6'd1, 4'd7, 1'b1, 64'h100, 1'b0);
    step();
    applyStimulus(1'b1, 6'd1, 4'd1, 1'b0, 64'd0, 1'b0);
    checkOutput("wr_n1", mhpmcntx_value, 64'h100);
    checkOutput("wr_keeps_ovf", {63'd0, mhpmcntx_ovf}, 64'd1);
    step();
    applyStimulus(1'b1, 6'd1, 4'd0, 1'b0, 64'd0, 1'b0);
    checkOutput("wr_n2", mhpmcntx_value, 64'h100);
    step();
    checkOutput("wr_n3_first", mhpmcntx_value, 64'h101);

    // A write of all-ones carries nothing; the following +1 wraps while ovf_clr is asserted.
    applyStimulus(1'b0, 6'd0, 4'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    step();
    applyStimulus(1'b1, 6'd1, 4'd1, 1'b0, 64'd0, 1'b0);
    checkOutput("clr_wr_noint", {63'd0, mhpmcntx_ovf_int}, 64'd0);
    step();
    applyStimulus(1'b1, 6'd1, 4'd0, 1'b0, 64'd0, 1'b1);
    step();
    applyStimulus(1'b0, 6'd0, 4'd0, 1'b0, 64'd0, 1'b0);
    checkOutput("clr_coll_ovf", {63'd0, mhpmcntx_ovf}, 64'd1);
    checkOutput("clr_coll_value", mhpmcntx_value, 64'd0);
    checkOutput("clr_coll_int", {63'd0, mhpmcntx_ovf_int}, 64'd1);
    step();
    applyStimulus(1'b0, 6'd0, 4'd0, 1'b0, 64'd0, 1'b1);
    step();
    applyStimulus(1'b0, 6'd0, 4'd0, 1'b0, 64'd0, 1'b0);
    checkOutput("clr_alone", {63'd0, mhpmcntx_ovf}, 64'd0);

    // Set the flag again so the mid-count reset has something to clear.
    applyStimulus(1'b0, 6'd0, 4'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    step();
    applyStimulus(1'b1, 6'd1, 4'd1, 1'b0, 64'd0, 1'b0);
    step();
    applyStimulus(1'b0, 6'd0, 4'd0, 1'b0, 64'd0, 1'b0);
    step();
    checkOutput("rst_pre_ovf", {63'd0, mhpmcntx_ovf}, 64'd1);

    // Reset mid-count: value 0x55 with inc_ff=4 in flight.
    applyStimulus(1'b0, 6'd0, 4'd0, 1'b1, 64'h55, 1'b0);
    step();
    applyStimulus(1'b1, 6'd1, 4'd4, 1'b0, 64'd0, 1'b0);
    step();
    applyStimulus(1'b1, 6'd1, 4'd0, 1'b0, 64'd0, 1'b0);
    checkOutput("rst_pre_value", mhpmcntx_value, 64'h55);
    cpurst = 1'b1;
    step();
    cpurst = 1'b0;
    applyStimulus(1'b1, 6'd1, 4'd2, 1'b0, 64'd0, 1'b0);
    checkOutput("rst_value", mhpmcntx_value, 64'd0);
    checkOutput("rst_ovf", {63'd0, mhpmcntx_ovf}, 64'd0);
    step();
    applyStimulus(1'b1, 6'd1, 4'd0, 1'b0, 64'd0, 1'b0);
    checkOutput("rst_no_stale", mhpmcntx_value, 64'd0);
    step();
    checkOutput("rst_first_inc", mhpmcntx_value, 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ct_hpcp_cntx_acc.md
CT_HPCP_CNTX_ACC -- requirements
Module: ct_hpcp_cntx_acc

Interface
REQ-001 SHALL have parameter EVT_MAX, default 42, the highest valid event select code.
REQ-002 SHALL have port forever_cpuclk  in  1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port cpurst  in  1: reset, synchronous and active-high.
REQ-004 SHALL have port mhpmcntx_adder  in  4: per-cycle increment from the event adder select stage; X when the select is invalid.
REQ-005 SHALL have port mhpmevtx_value  in  6: event select code [5:0] for this counter.
REQ-006 SHALL have port hpcp_cnt_en  in  1: count enable (not inhibited, privilege mode allowed).
REQ-007 SHALL have port mhpmcntx_wen  in  1: CSR write strobe.
REQ-008 SHALL have port mhpmcntx_wdata  in  64: CSR write data.
REQ-009 SHALL have port mhpmcntx_ovf_clr  in  1: clear request for the sticky overflow flag.
REQ-010 SHALL have port mhpmcntx_value  out  64: current counter value, driven from a register.
REQ-011 SHALL have port mhpmcntx_ovf  out  1: sticky overflow flag.
REQ-012 SHALL have port mhpmcntx_ovf_int  out  1: one-cycle overflow interrupt pulse.

Function
REQ-013 SHALL implement a 2-stage pipeline: stage 1 is the increment register inc_ff[3:0]; stage 2 is the 64-bit counter register.
REQ-014 Stage 1 SHALL load mhpmcntx_adder when hpcp_cnt_en=1 and 1<=mhpmevtx_value<=EVT_MAX; otherwise it SHALL load 0.
REQ-015 No X on mhpmcntx_adder SHALL ever reach inc_ff when the select is invalid or the counter is disabled.
REQ-016 Stage 2 SHALL load counter + zero-extended inc_ff each cycle, computed modulo 2^64 (wrap-around).
REQ-017 Latency: an increment presented in cycle N SHALL be visible on mhpmcntx_value in cycle N+2.
REQ-018 A write in cycle N SHALL load mhpmcntx_wdata into the counter at the end of cycle N, and mhpmcntx_value SHALL equal wdata in cycle N+1.
REQ-019 On a write, the in-flight inc_ff SHALL be discarded (not added) and inc_ff SHALL load 0, so events presented in cycle N are dropped.
REQ-020 The first event counted after a write SHALL be one presented in cycle N+1, visible in cycle N+3.
REQ-021 A carry-out from the 64-bit add SHALL set mhpmcntx_ovf at the same edge the wrapped value is loaded.
REQ-022 A carry-out SHALL also drive mhpmcntx_ovf_int high for exactly one cycle.
REQ-023 mhpmcntx_ovf SHALL remain set until mhpmcntx_ovf_clr is asserted.
REQ-024 If overflow and ovf_clr occur in the same cycle, set SHALL win (ovf stays 1).
REQ-025 A CSR write SHALL NOT modify mhpmcntx_ovf and SHALL NOT generate an overflow.
REQ-026 With inc_ff=0 the counter SHALL hold its value; there is no other hold or gating path.
REQ-027 A change to mhpmevtx_value SHALL take effect on the next sampled cycle; any increment already in inc_ff SHALL still be added.

Reset
REQ-028 While cpurst=1, at each clock edge: counter=0, inc_ff=0, mhpmcntx_ovf=0, mhpmcntx_ovf_int=0.
REQ-029 Reset SHALL take priority over mhpmcntx_wen, the increment path and ovf_clr.
REQ-030 Asserting reset mid-count SHALL discard any in-flight increment.
REQ-031 The first increment counted after reset release SHALL be one presented in the first cycle with cpurst=0.

Verification
REQ-032 Counting: after reset, select=1, en=1, adder=3 held for 4 cycles from cycle 0 -> mhpmcntx_value reads 0,0,3,6,9,12 in cycles 0..5.
REQ-033 Invalid select: select=0, then select=43, with adder=X then 4'hF, en=1 -> counter unchanged; no X on mhpmcntx_value.
REQ-034 Overflow: write 64'hFFFF_FFFF_FFFF_FFFE, then adder=5 for one cycle -> value=3, ovf=1, ovf_int high for exactly 1 cycle, ovf still 1 after 10 idle cycles.
REQ-035 Write collision: adder=2 in cycle N-1, write 64'h100 in cycle N with adder=7 -> value=64'h100 in cycles N+1 and N+2.
REQ-036 Clear collision: ovf=1, then ovf_clr in the same cycle as a new overflow -> ovf stays 1; ovf_clr alone in a later cycle -> ovf=0 next cycle.
REQ-037 Reset mid-count: value=64'h55 with inc_ff=4, assert cpurst for 1 cycle -> value=0 and ovf=0 next cycle; no stale +4 added after release.
